// File: rtl/fmap_pingpong_buffer.sv
// Two-bank ping-pong feature-map buffer: a raster writer fills one bank
// while the consumer randomly reads the other, full frame by full frame.
module fmap_pingpong_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 64,
    parameter int WIDTH      = 6,
    parameter int HEIGHT     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic                           frame_done,
    output logic                           out_valid,
    input  logic                           rd_en,
    input  logic [$clog2(HEIGHT)-1:0]      rd_row,
    input  logic [$clog2(WIDTH)-1:0]       rd_col,
    output logic [CHANNELS*DATA_WIDTH-1:0] rd_data,
    output logic                           rd_data_valid,
    input  logic                           rd_release,
    output logic [1:0]                     occupancy
);

    localparam int PW    = CHANNELS * DATA_WIDTH;
    localparam int RW    = $clog2(HEIGHT);
    localparam int CW    = $clog2(WIDTH);
    localparam int DEPTH = HEIGHT * WIDTH;
    localparam int IW    = $clog2(DEPTH);

    localparam logic [RW:0]   ROW_LIM  = (RW+1)'(HEIGHT);
    localparam logic [CW:0]   COL_LIM  = (CW+1)'(WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

    logic [PW-1:0] r_mem [2][DEPTH];

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [1:0]    r_full;
    logic          r_frame_done;
    logic [PW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic [1:0]    r_occ;

    logic          w_accept;
    logic          w_last;
    logic          w_release;
    logic          w_rd_fire;
    logic          w_rd_oob;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic [1:0]    w_full_nxt;

    assign in_ready      = !r_full[r_wr_bank];
    assign out_valid     = r_full[r_rd_bank];
    assign frame_done    = r_frame_done;
    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_rd_valid;
    assign occupancy     = r_occ;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_release = rd_release && out_valid;
    assign w_rd_fire = rd_en && out_valid;

    assign w_wr_idx = IW'(r_row) * IW'(WIDTH) + IW'(r_col);
    assign w_rd_idx = IW'(rd_row) * IW'(WIDTH) + IW'(rd_col);
    assign w_rd_oob = ({1'b0, rd_row} >= ROW_LIM)
                   || ({1'b0, rd_col} >= COL_LIM);

    // Completion and release can never target the same bank, so both apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_accept && w_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_bank][w_wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row        <= '0;
            r_col        <= '0;
            r_wr_bank    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_last;
            if (w_accept) begin
                if (w_last) begin
                    r_row     <= '0;
                    r_col     <= '0;
                    r_wr_bank <= !r_wr_bank;
                end else if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full    <= 2'b00;
            r_occ     <= 2'd0;
            r_rd_bank <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            r_occ  <= {1'b0, w_full_nxt[0]} + {1'b0, w_full_nxt[1]};
            if (w_release) begin
                r_rd_bank <= !r_rd_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_data <= w_rd_oob ? '0 : r_mem[r_rd_bank][w_rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_fmap_pingpong_buffer.sv
// Directed bench for fmap_pingpong_buffer with a bank model and a
// read scoreboard queue; 4 channels, 6x8 frames.
module tb_fmap_pingpong_buffer;

    localparam int DW = 32;
    localparam int CH = 4;
    localparam int W  = 6;
    localparam int H  = 8;
    localparam int PW = CH * DW;
    localparam int NB = W * H;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          frame_done;
    logic          out_valid;
    logic          rd_en;
    logic [2:0]    rd_row;
    logic [2:0]    rd_col;
    logic [PW-1:0] rd_data;
    logic          rd_data_valid;
    logic          rd_release;
    logic [1:0]    occupancy;

    fmap_pingpong_buffer #(
        .DATA_WIDTH(DW),
        .CHANNELS  (CH),
        .WIDTH     (W),
        .HEIGHT    (H)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .frame_done   (frame_done),
        .out_valid    (out_valid),
        .rd_en        (rd_en),
        .rd_row       (rd_row),
        .rd_col       (rd_col),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .rd_release   (rd_release),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    int vectors;
    int miss;
    int fd_cnt = 0;
    int fd_base;

    logic [PW-1:0] m_mem [2][NB];
    logic [PW-1:0] sbq [$];
    logic [PW-1:0] m_last_rd;
    int            m_cnt;
    bit            m_wr;
    bit            m_rd;
    bit [1:0]      m_full;

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_cnt = fd_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [PW-1:0] pix(input int f, input int b);
        logic [PW-1:0] p;
        for (int c = 0; c < CH; c++) begin
            p[c*DW +: DW] = {8'(f), 16'(b), 8'(c)};
        end
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [PW-1:0] obs,
                         input logic [PW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_in_ready"}, in_ready, !m_full[m_wr]);
        check({tag, "_out_valid"}, out_valid, m_full[m_rd]);
        check({tag, "_occupancy"}, occupancy,
              2'(m_full[0]) + 2'(m_full[1]));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        rd_en      = 1'b0;
        rd_release = 1'b0;
        tick();
        tick();
        m_cnt  = 0;
        m_wr   = 1'b0;
        m_rd   = 1'b0;
        m_full = 2'b00;
        sbq.delete();
        m_last_rd = '0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_rd_valid", rd_data_valid, 1'b0);
        check("rst_rd_data", rd_data, '0);
        rst_n = 1'b1;
    endtask

    task automatic push_beat(input int f, input int b, input bit rel);
        int n;
        bit rel_ok;
        n        = 0;
        in_valid = 1'b1;
        in_data  = pix(f, b);
        while (!in_ready && n < 64) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1'b1);
        end
        rd_release = rel;
        rel_ok     = rel && m_full[m_rd];
        tick();
        rd_release = 1'b0;
        m_mem[m_wr][m_cnt] = pix(f, b);
        m_cnt++;
        if (rel_ok) begin
            m_full[m_rd] = 1'b0;
            m_rd         = ~m_rd;
        end
        if (m_cnt == NB) begin
            m_cnt        = 0;
            m_full[m_wr] = 1'b1;
            m_wr         = ~m_wr;
        end
    endtask

    task automatic push_frame(input int f, input bit rel_last);
        for (int b = 0; b < NB; b++) begin
            push_beat(f, b, rel_last && (b == NB - 1));
        end
        check("frame_done_set", frame_done, 1'b1);
    endtask

    task automatic release_frame();
        bit rel_ok;
        rel_ok     = m_full[m_rd];
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        if (rel_ok) begin
            m_full[m_rd] = 1'b0;
            m_rd         = ~m_rd;
        end
    endtask

    task automatic do_read(input int r, input int c);
        bit            exp_v;
        logic [PW-1:0] e;
        exp_v  = m_full[m_rd];
        rd_en  = 1'b1;
        rd_row = 3'(r);
        rd_col = 3'(c);
        if (exp_v) begin
            if (r < H && c < W) sbq.push_back(m_mem[m_rd][r*W + c]);
            else                sbq.push_back('0);
        end
        tick();
        rd_en = 1'b0;
        check("rd_valid", rd_data_valid, exp_v);
        if (exp_v) begin
            e = sbq.pop_front();
            check("rd_data", rd_data, e);
            m_last_rd = e;
        end else begin
            check("rd_data_hold", rd_data, m_last_rd);
        end
    endtask

    initial begin
        clk        = 1'b0;
        vectors    = 0;
        miss       = 0;
        in_data    = '0;
        rd_row     = '0;
        rd_col     = '0;
        do_reset();

        fd_base = fd_cnt;
        push_frame(1, 1'b0);
        in_valid = 1'b0;
        tick();
        check("frame_done_clear", frame_done, 1'b0);
        check("frame_done_once", 32'(fd_cnt - fd_base), 1);
        check_status("f1");
        check("f1_occ_one", occupancy, 2'd1);
        do_read(7, 5);
        do_read(0, 0);
        do_read(3, 2);
        do_read(7, 6);
        do_read(0, 7);

        push_frame(2, 1'b1);
        in_valid = 1'b0;
        check_status("rel_on_last");
        check("rel_on_last_occ", occupancy, 2'd1);
        tick();
        do_read(7, 5);
        do_read(0, 0);
        release_frame();
        check_status("empty");
        do_read(1, 1);
        release_frame();
        push_frame(3, 1'b0);
        in_valid = 1'b0;
        tick();
        check_status("f3");
        do_read(2, 3);

        do_reset();
        fd_base = fd_cnt;
        push_frame(1, 1'b0);
        check("zero_bubble_ready", in_ready, 1'b1);
        push_frame(2, 1'b0);
        check_status("both_full");
        check("both_full_ready", in_ready, 1'b0);
        check("both_full_occ", occupancy, 2'd2);
        in_valid = 1'b1;
        in_data  = pix(3, 0);
        tick();
        tick();
        tick();
        check("held_ready", in_ready, 1'b0);
        check("two_frames", 32'(fd_cnt - fd_base), 2);
        do_read(4, 4);
        release_frame();
        check("freed_ready", in_ready, 1'b1);
        for (int b = 0; b < NB; b++) begin
            push_beat(3, b, 1'b0);
        end
        in_valid = 1'b0;
        tick();
        check_status("f3b");
        release_frame();
        do_read(0, 0);
        do_read(7, 5);

        do_reset();
        for (int b = 0; b <= 20; b++) begin
            push_beat(9, b, 1'b0);
        end
        in_valid = 1'b0;
        do_reset();
        fd_base = fd_cnt;
        for (int b = 0; b < NB - 1; b++) begin
            push_beat(4, b, 1'b0);
        end
        check("no_early_done", 32'(fd_cnt - fd_base), 0);
        check("no_early_valid", out_valid, 1'b0);
        push_beat(4, NB - 1, 1'b0);
        check("post_rst_done", frame_done, 1'b1);
        in_valid = 1'b0;
        tick();
        check_status("post_rst");
        do_read(0, 0);
        do_read(7, 5);

        check("sb_empty", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
